// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider.
// State encoding and the minimum legal ratio.
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    localparam int unsigned DIV_MIN = 2;

endpackage

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider, near-50% duty.
// Ratio changes take effect only at period boundaries.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int DIV_RST = 4
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_div,
    input  logic             i_div_load,
    output logic             o_clk,
    output logic             o_rise_en,
    output logic             o_fall_en,
    output logic [CNT_W-1:0] o_div_active,
    output logic             o_busy
);

    if (DIV_RST < 2) begin : g_bad_div_rst
        $error("clk_div_prog: DIV_RST must be >= 2");
    end

    // Ratios 0 and 1 are meaningless; treat them as the minimum.
    function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] n);
        return (n < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : n;
    endfunction

    // High-phase length ceil(n/2), one extra bit so n = all-ones is safe.
    function automatic logic [CNT_W-1:0] half(input logic [CNT_W-1:0] n);
        logic [CNT_W:0] t;
        t = {1'b0, n} + {{CNT_W{1'b0}}, 1'b1};
        return t[CNT_W:1];
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             busy_q, busy_d;
    logic             clk_q, clk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             arm_q;
    logic             run_d;
    logic             wrap;
    logic [CNT_W-1:0] new_div;
    logic [CNT_W-1:0] h_d;

    // Blocks the first edge after reset release from leaving IDLE.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            arm_q <= 1'b0;
        end else begin
            arm_q <= 1'b1;
        end
    end

    // Next-state: FSM, counter, active/pending ratio and phase outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        run_d   = 1'b0;
        new_div = clamp(i_div);
        wrap    = (cnt_q == (div_q - CNT_W'(1)));
        unique case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                busy_d = 1'b0;
                if (i_div_load) begin
                    div_d = new_div;
                end
                if (i_en && arm_q) begin
                    state_d = ST_RUN;
                    run_d   = 1'b1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                run_d = 1'b1;
                if (wrap) begin
                    cnt_d  = '0;
                    busy_d = 1'b0;
                    if (i_div_load) begin
                        div_d = new_div;
                    end else if (busy_q) begin
                        div_d = pend_q;
                    end
                    if ((state_q == ST_DRAIN) && !i_en) begin
                        state_d = ST_IDLE;
                        run_d   = 1'b0;
                    end else begin
                        state_d = i_en ? ST_RUN : ST_DRAIN;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (i_div_load) begin
                        pend_d = new_div;
                        busy_d = 1'b1;
                    end
                    state_d = i_en ? ST_RUN : ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        h_d    = half(div_d);
        clk_d  = run_d && (cnt_d < h_d);
        rise_d = run_d && (cnt_d == '0);
        fall_d = run_d && (cnt_d == h_d);
    end

    // State and output registers.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= CNT_W'(DIV_RST);
            pend_q  <= CNT_W'(DIV_RST);
            busy_q  <= 1'b0;
            clk_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            clk_q   <= clk_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o_clk        = clk_q;
    assign o_rise_en    = rise_q;
    assign o_fall_en    = fall_q;
    assign o_div_active = div_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed testbench for clk_div_prog.
// Outputs are sampled 1 time unit after each rising edge.
module tb_clk_div_prog;

    localparam int CNT_W = 16;

    logic             sys_clk;
    logic             rst;
    logic             i_en;
    logic [CNT_W-1:0] i_div;
    logic             i_div_load;
    logic             o_clk;
    logic             o_rise_en;
    logic             o_fall_en;
    logic [CNT_W-1:0] o_div_active;
    logic             o_busy;

    int total = 0;
    int bad   = 0;

    clk_div_prog #(
        .CNT_W  (CNT_W),
        .DIV_RST(4)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .i_en        (i_en),
        .i_div       (i_div),
        .i_div_load  (i_div_load),
        .o_clk       (o_clk),
        .o_rise_en   (o_rise_en),
        .o_fall_en   (o_fall_en),
        .o_div_active(o_div_active),
        .o_busy      (o_busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic ck(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // One cycle, then check {o_clk, o_rise_en, o_fall_en}.
    task automatic cyc(input string tag, input logic [2:0] e);
        tick();
        ck(tag, {29'd0, o_clk, o_rise_en, o_fall_en}, {29'd0, e});
    endtask

    task automatic dv(input string tag, input int d, input logic b);
        ck({tag, "_div"}, {16'd0, o_div_active}, d);
        ck({tag, "_busy"}, {31'd0, o_busy}, {31'd0, b});
    endtask

    task automatic load(input int d);
        i_div      = CNT_W'(d);
        i_div_load = 1'b1;
    endtask

    initial begin
        rst        = 1'b1;
        i_en       = 1'b0;
        i_div      = '0;
        i_div_load = 1'b0;
        #2;
        ck("rst_out", {29'd0, o_clk, o_rise_en, o_fall_en}, 32'd0);
        dv("rst", 4, 1'b0);

        // Scenario 1: /4 after reset, i_en already high.
        tick();
        tick();
        i_en = 1'b1;
        rst  = 1'b0;
        cyc("s1_idle_edge", 3'b000);
        cyc("s1_c0", 3'b110);
        dv("s1", 4, 1'b0);
        cyc("s1_c1", 3'b100);
        cyc("s1_c2", 3'b001);
        cyc("s1_c3", 3'b000);
        cyc("s1_c0b", 3'b110);
        cyc("s1_c1b", 3'b100);

        // Scenario 2: load 5 at counter 1.
        load(5);
        cyc("s2_c2", 3'b001);
        i_div_load = 1'b0;
        dv("s2_c2", 4, 1'b1);
        cyc("s2_c3", 3'b000);
        dv("s2_c3", 4, 1'b1);
        cyc("s2_c0", 3'b110);
        dv("s2_c0", 5, 1'b0);
        cyc("s2_c1", 3'b100);
        cyc("s2_c2b", 3'b100);
        cyc("s2_c3b", 3'b001);
        cyc("s2_c4", 3'b000);
        cyc("s2_c0b", 3'b110);

        // Scenario 3: load 0 then 1, both clamp to 2.
        load(0);
        cyc("s3_c1", 3'b100);
        dv("s3_c1", 5, 1'b1);
        load(1);
        cyc("s3_c2", 3'b100);
        i_div_load = 1'b0;
        cyc("s3_c3", 3'b001);
        cyc("s3_c4", 3'b000);
        cyc("s3_c0", 3'b110);
        dv("s3_c0", 2, 1'b0);
        cyc("s3_c1b", 3'b001);
        cyc("s3_c0b", 3'b110);
        cyc("s3_c1c", 3'b001);

        // Scenario 4: load 6 exactly at a wrap, then drain.
        load(6);
        cyc("s4_c0", 3'b110);
        i_div_load = 1'b0;
        dv("s4_wrapload", 6, 1'b0);
        cyc("s4_c1", 3'b100);
        i_en = 1'b0;
        cyc("s4_c2", 3'b100);
        cyc("s4_c3", 3'b001);
        cyc("s4_c4", 3'b000);
        cyc("s4_c5", 3'b000);
        cyc("s4_idle0", 3'b000);
        cyc("s4_idle1", 3'b000);
        cyc("s4_idle2", 3'b000);
        i_en = 1'b1;
        cyc("s4_r_c0", 3'b110);
        cyc("s4_r_c1", 3'b100);
        cyc("s4_r_c2", 3'b100);
        i_en = 1'b0;
        cyc("s4_r_c3", 3'b001);
        cyc("s4_r_c4", 3'b000);
        i_en = 1'b1;
        cyc("s4_r_c5", 3'b000);
        cyc("s4_r_c0b", 3'b110);
        cyc("s4_r_c1b", 3'b100);

        // Scenario 5: loads 7 then 9 back to back; only 9 applies.
        load(7);
        cyc("s5_c2", 3'b100);
        dv("s5_c2", 6, 1'b1);
        load(9);
        cyc("s5_c3", 3'b001);
        i_div_load = 1'b0;
        dv("s5_c3", 6, 1'b1);
        cyc("s5_c4", 3'b000);
        cyc("s5_c5", 3'b000);
        dv("s5_c5", 6, 1'b1);
        cyc("s5_c0", 3'b110);
        dv("s5_c0", 9, 1'b0);
        cyc("s5_c1", 3'b100);
        cyc("s5_c2b", 3'b100);
        cyc("s5_c3b", 3'b100);
        cyc("s5_c4b", 3'b100);
        cyc("s5_c5b", 3'b001);
        cyc("s5_c6", 3'b000);
        cyc("s5_c7", 3'b000);
        cyc("s5_c8", 3'b000);
        cyc("s5_c0b", 3'b110);
        cyc("s5_c1b", 3'b100);

        // Scenario 6: asynchronous reset mid high phase.
        #2;
        rst = 1'b1;
        #1;
        ck("s6_rst_out", {29'd0, o_clk, o_rise_en, o_fall_en}, 32'd0);
        dv("s6_rst", 4, 1'b0);
        tick();
        rst = 1'b0;
        cyc("s6_idle_edge", 3'b000);
        cyc("s6_c0", 3'b110);
        dv("s6_c0", 4, 1'b0);
        cyc("s6_c1", 3'b100);
        cyc("s6_c2", 3'b001);
        cyc("s6_c3", 3'b000);
        cyc("s6_c0b", 3'b110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable integer clock divider for the single `sys_clk` domain. It generalises the fixed divide-by-4 block to any ratio N ≥ 2 with near-50 % duty, and applies ratio changes glitch-free at period boundaries. It provides an orderly enable/drain sequence and single-cycle rise/fall enables for logic that stays on `sys_clk`. It feeds baud, SPI-SCLK and LED-strobe generators; `o_clk` is a fabric signal and does not drive a clock tree.

## Interface
- `CNT_W`, 16: width of the ratio and of the internal counter.
- `DIV_RST`, 4: ratio active after reset. Must be ≥ 2, enforced by an elaboration-time check.

- `sys_clk`  in  1: the only clock.
- `rst`  in  1: asynchronous, active-high reset.
- `i_en`  in  1: run request (level).
- `i_div`  in  CNT_W: requested ratio N, unsigned.
- `i_div_load`  in  1: single-cycle strobe that captures `i_div`.
- `o_clk`  out  1: divided clock, registered.
- `o_rise_en`  out  1: high for exactly the first `sys_clk` cycle of each `o_clk` high phase.
- `o_fall_en`  out  1: high for exactly the first cycle of each `o_clk` low phase.
- `o_div_active`  out  CNT_W: ratio currently in effect, after clamping.
- `o_busy`  out  1: a loaded ratio is pending and not yet applied.

## Operation
- **Reset values:**
  - `o_clk`=0, `o_rise_en`=0, `o_fall_en`=0, `o_busy`=0.
  - `o_div_active`=DIV_RST; counter=0; state IDLE.
- **Clamp:** any captured N < 2 (0 or 1) is stored and reported as 2.
- **Phases for active ratio N:**
  - Counter runs 0..N-1 and wraps to 0.
  - H = ceil(N/2), computed in CNT_W+1 bits so N = 2^CNT_W-1 does not overflow.
  - `o_clk` is 1 for counter 0..H-1 and 0 for counter H..N-1.
  - Resulting split: N=4 gives 2 high / 2 low; N=5 gives 3 high / 2 low; N=2 gives 1/1.
- **State machine:**
  - IDLE: counter held at 0, `o_clk`=0, no pulses. `i_en`=1 → RUN, with counter=0 and `o_clk`=1 at the next edge.
  - RUN: counts. `i_en`=0 → DRAIN; the counter keeps running.
  - DRAIN: completes the current period. At the wrap (counter = N-1), go to IDLE if `i_en`=0, otherwise continue in RUN with no gap. If `i_en` returns to 1 before the wrap, go back to RUN with no phase disturbance.
- **Ratio load:**
  - `i_div_load`=1 captures clamp(`i_div`) into a pending register and sets `o_busy`.
  - In RUN or DRAIN, the pending value becomes active at the wrap edge; the next period uses it from counter 0 and `o_busy` clears.
  - In IDLE, the value applies at the next edge.
  - Load while busy: the last load wins; the earlier pending value is discarded.
  - Load in the same cycle as a wrap: the newly loaded value applies at that wrap; `o_busy` never asserts.
- A ratio never changes mid-period, so no runt high or low phase ever appears on `o_clk`.

## Timing
- `i_en` sampled 1 at edge E in IDLE → after E: `o_clk`=1 and `o_rise_en`=1 (1-cycle latency).
- `o_rise_en` coincides with counter = 0 while running. `o_fall_en` coincides with counter = H.
- Each of `o_rise_en` and `o_fall_en` fires exactly once per period.
- `o_div_active` updates in the same cycle that the new period's `o_rise_en` asserts.
- `o_busy` rises in the cycle after the load edge and falls in the cycle after the applying edge.
- `rst` asserted at any time clears all outputs immediately (asynchronous). On release, the block starts in IDLE at the first edge after release, regardless of the `i_en` level.

## Structure
- Shared package `clk_div_pkg`: state encoding (IDLE, RUN, DRAIN) and the constant `DIV_MIN`=2.
- Single module with no sub-module. The counter, phase compare, FSM and pending-load register are all local.

## Test plan
- Reset with DIV_RST=4, `i_en`=1 → `o_clk` pattern 1,1,0,0 repeating; `o_rise_en` every 4th cycle starting 1 cycle after `i_en`; `o_div_active`=4.
- Load 5 at counter=1 → current period finishes as 2 high / 2 low, then 3 high / 2 low; `o_busy` high for 2 cycles.
- Load 0, then load 1 → `o_div_active`=2 and `o_clk` toggles every cycle; no pulse is missed or doubled.
- N=6, drop `i_en` at counter=1 → 3 high / 3 low completes, then `o_clk` stays 0 with no pulses. In a repeat run, re-raise `i_en` at counter=4 → next period starts with no gap.
- Loads of 7 then 9 on consecutive cycles mid-period → only 9 is applied (5 high / 4 low); 7 never appears on `o_div_active`.
- Assert `rst` mid high phase with N=9 → `o_clk`=0 immediately and `o_div_active`=4. After release, the block stays in IDLE for one edge, then restarts as in scenario 1.
